restador_serial: RTL
====================

RESTADOR_SERIAL -- requirements
Module: restador_serial

Interface
REQ-001 Parameter ANCHO, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Inicio  input  1  start request; sampled only in REPOSO.
REQ-005 X  input  ANCHO  minuend, unsigned; captured on the start edge.
REQ-006 Y  input  ANCHO  subtrahend, unsigned; captured on the start edge.
REQ-007 Ocupado  output  1  high while in RESTANDO or FIN.
REQ-008 Listo  output  1  one-cycle completion pulse, high only in FIN.
REQ-009 R  output  ANCHO  difference X-Y mod 2^ANCHO, registered.
REQ-010 Prestamo  output  1  final borrow; 1 iff X < Y (unsigned), registered.

Function
REQ-011 The block SHALL compute X-Y bit-serially, LSB first, one bit per clock, through a single full-subtractor stage.
REQ-012 FSM states SHALL be REPOSO, RESTANDO and FIN, encoded as 2 bits.
REQ-013 REPOSO -> RESTANDO SHALL occur on an edge with Inicio=1, at which X and Y load into shift registers, the borrow flop clears to 0 and the bit counter clears to 0.
REQ-014 Each RESTANDO edge SHALL apply operand LSBs and the borrow flop to the stage, shift the stage difference bit into the MSB of an internal result shift register, load stage borrow-out into the borrow flop, shift both operand registers right and increment the counter.
REQ-015 RESTANDO -> FIN SHALL occur on the edge processing bit ANCHO-1, at which R takes the completed result and Prestamo takes the final borrow-out.
REQ-016 FIN -> REPOSO SHALL occur unconditionally on the next edge.
REQ-017 Listo SHALL be high exactly one cycle, ANCHO+1 rising edges after the edge sampling Inicio (counting that edge as the first).
REQ-018 Inicio SHALL be ignored in RESTANDO and FIN; X/Y changes after the start edge SHALL NOT affect the result.
REQ-019 Inicio held high continuously SHALL restart on the first edge back in REPOSO; back-to-back operations SHALL therefore have period ANCHO+2 cycles.
REQ-020 R and Prestamo SHALL hold their last values until the next FIN entry; they SHALL NOT toggle during RESTANDO.
REQ-021 The bit counter SHALL be $clog2(ANCHO) bits wide and SHALL NOT wrap during a valid operation.

Reset
REQ-022 rst_n low SHALL immediately force state REPOSO, R=0, Prestamo=0, Listo=0, Ocupado=0, and clear counter, borrow flop and shift registers.
REQ-023 Reset asserted mid-operation SHALL abort it with no Listo pulse; after release the block SHALL wait for a new Inicio.

Structure
REQ-024 Package restador_pkg SHALL hold the state encoding constants (REPOSO=0, RESTANDO=1, FIN=2) and the default width constant 8.
REQ-025 The existing Restador_Completo module SHALL be instantiated once as the only sub-module (X, Y, CarrieNEntrada in; R, CarrieNSalida out); no other arithmetic SHALL compute the difference.

Verification
REQ-026 ANCHO=8, X=0x35, Y=0x12, Inicio pulse -> Listo after 9 edges, R=0x23, Prestamo=0.
REQ-027 X=0x12, Y=0x35 -> R=0xDD, Prestamo=1; X=0x00, Y=0x01 -> R=0xFF, Prestamo=1.
REQ-028 X=0xFF, Y=0xFF -> R=0x00, Prestamo=0; X=0x80, Y=0x7F -> R=0x01, Prestamo=0.
REQ-029 Start 0x35-0x12, then pulse Inicio and change X/Y to 0x00/0xFF during RESTANDO -> single Listo, R=0x23; Inicio held high -> Listo pulses every 10 cycles.
REQ-030 rst_n low after 4 RESTANDO edges -> R=0, Prestamo=0, Ocupado=0 immediately, no Listo; next start 0x10-0x01 -> R=0x0F, Prestamo=0.
REQ-031 Exhaustive ANCHO=4 sweep of all 256 X/Y pairs -> R=(X-Y) mod 16 and Prestamo=(X<Y) on every Listo, checked against a reference model.

Source files
------------

// File: rtl/restador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : restador_pkg
//  Description : Shared state encoding and default width for restador_serial.
//  Revision    : 1.0 - initial release
// ============================================================================
package restador_pkg;

    localparam int ANCHO_DEF = 8;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        RESTANDO = 2'd1,
        FIN      = 2'd2
    } estado_t;

endpackage : restador_pkg
`default_nettype wire

// File: rtl/Restador_Completo.sv
`default_nettype none
// ============================================================================
//  Module      : Restador_Completo
//  Description : One-bit full subtractor (X - Y - borrow in).
//  Revision    : 1.0 - initial release
// ============================================================================
module Restador_Completo (
    input  logic X,
    input  logic Y,
    input  logic CarrieNEntrada,
    output logic R,
    output logic CarrieNSalida
);

    assign R             = X ^ Y ^ CarrieNEntrada;
    // Borrow out when Y exceeds X, or when they are equal and a borrow is pending.
    assign CarrieNSalida = (~X & Y) | (~(X ^ Y) & CarrieNEntrada);

endmodule : Restador_Completo
`default_nettype wire

// File: rtl/restador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : restador_serial
//  Description : Bit-serial unsigned subtractor, LSB first, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module restador_serial
    import restador_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Inicio,
    input  logic [ANCHO-1:0] X,
    input  logic [ANCHO-1:0] Y,
    output logic             Ocupado,
    output logic             Listo,
    output logic [ANCHO-1:0] R,
    output logic             Prestamo
);

    localparam int            CW     = $clog2(ANCHO);
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

    if (ANCHO < 2) begin : g_ancho_invalido
        $error("restador_serial: ANCHO must be >= 2");
    end

    estado_t          estado;
    estado_t          estado_sig;
    logic             arrancar;
    logic [ANCHO-1:0] x_sr;
    logic [ANCHO-1:0] y_sr;
    logic [ANCHO-1:0] res_sr;
    logic [ANCHO-1:0] res_sig;
    logic [CW-1:0]    cuenta;
    logic             prestamo_ff;
    logic             dif_bit;
    logic             prestamo_sal;
    logic             ultimo_bit;

    Restador_Completo u_etapa (
        .X              (x_sr[0]),
        .Y              (y_sr[0]),
        .CarrieNEntrada (prestamo_ff),
        .R              (dif_bit),
        .CarrieNSalida  (prestamo_sal)
    );

    assign ultimo_bit = (cuenta == ULTIMO);
    // Difference bits enter at the MSB so the word is aligned after ANCHO shifts.
    assign res_sig    = {dif_bit, {(ANCHO-1){1'b0}}} | (res_sr >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        arrancar   = 1'b0;
        Ocupado    = 1'b0;
        Listo      = 1'b0;
        case (estado)
            REPOSO: begin
                if (Inicio) begin
                    estado_sig = RESTANDO;
                    arrancar   = 1'b1;
                end
            end
            RESTANDO: begin
                Ocupado = 1'b1;
                if (ultimo_bit) begin
                    estado_sig = FIN;
                end
            end
            FIN: begin
                Ocupado    = 1'b1;
                Listo      = 1'b1;
                estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sr        <= '0;
            y_sr        <= '0;
            res_sr      <= '0;
            cuenta      <= '0;
            prestamo_ff <= 1'b0;
            R           <= '0;
            Prestamo    <= 1'b0;
        end else if (arrancar) begin
            x_sr        <= X;
            y_sr        <= Y;
            res_sr      <= '0;
            cuenta      <= '0;
            prestamo_ff <= 1'b0;
        end else if (estado == RESTANDO) begin
            x_sr        <= x_sr >> 1;
            y_sr        <= y_sr >> 1;
            res_sr      <= res_sig;
            prestamo_ff <= prestamo_sal;
            // Counter parks on the last index instead of wrapping.
            if (ultimo_bit) begin
                R        <= res_sig;
                Prestamo <= prestamo_sal;
            end else begin
                cuenta   <= cuenta + CW'(1);
            end
        end
    end

endmodule : restador_serial
`default_nettype wire
